// File: rtl/alu_threaded.sv
// -----------------------------------------------------------------------------
// alu_threaded
//
// Fully pipelined, fixed-latency integer ALU for a barrel-threaded datapath.
// Each issued operation retires exactly PIPE_DEPTH cycles after it is sampled.
// Every hardware thread owns a private carry flop. The carry is read
// combinationally at issue and written on the same edge that registers R.
//
// Optional feature macro:
//   ALU_MULT_EN  defined   -> multiplier present (MUL_LO, MUL_HI, MULS_HI).
//                undefined -> opcodes 12..14 return R=0 and leave carry as is.
//
// Ports:
//   clock         in   sole clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   in_valid      in   operation present this cycle
//   thread_in     in   issuing thread          [TID_WIDTH]
//   op_in         in   opcode                  [OPCODE_WIDTH]
//   D_in          in   destination operand     [D_OPERAND_WIDTH]
//   A, B          in   operands                [WORD_WIDTH]
//   out_valid     out  result valid
//   thread_out    out  thread of result        [TID_WIDTH]
//   op_out        out  opcode of result        [OPCODE_WIDTH]
//   D_out         out  delayed D               [D_OPERAND_WIDTH]
//   R             out  result                  [WORD_WIDTH]
//   carry_out     out  thread's carry after this op
//   zero_out      out  R == 0
//   negative_out  out  R[WORD_WIDTH-1]
//
// Handshake: no handshake. in_valid qualifies the issue slot; out_valid
// qualifies the retirement slot. There is no backpressure and no stall.
// -----------------------------------------------------------------------------
module alu_threaded #(
    parameter int WORD_WIDTH      = 36,
    parameter int OPCODE_WIDTH    = 4,
    parameter int D_OPERAND_WIDTH = 10,
    parameter int THREAD_COUNT    = 8,
    parameter int PIPE_DEPTH      = 8,
    parameter int TID_WIDTH       = $clog2(THREAD_COUNT)
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       in_valid,
    input  logic [TID_WIDTH-1:0]       thread_in,
    input  logic [OPCODE_WIDTH-1:0]    op_in,
    input  logic [D_OPERAND_WIDTH-1:0] D_in,
    input  logic [WORD_WIDTH-1:0]      A,
    input  logic [WORD_WIDTH-1:0]      B,
    output logic                       out_valid,
    output logic [TID_WIDTH-1:0]       thread_out,
    output logic [OPCODE_WIDTH-1:0]    op_out,
    output logic [D_OPERAND_WIDTH-1:0] D_out,
    output logic [WORD_WIDTH-1:0]      R,
    output logic                       carry_out,
    output logic                       zero_out,
    output logic                       negative_out
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (WORD_WIDTH < 8) begin : g_bad_word_width
        $error("alu_threaded: WORD_WIDTH must be >= 8");
    end
    if (OPCODE_WIDTH != 4) begin : g_bad_opcode_width
        $error("alu_threaded: OPCODE_WIDTH must be 4");
    end
    if (THREAD_COUNT < 2) begin : g_bad_thread_count
        $error("alu_threaded: THREAD_COUNT must be >= 2");
    end
    if (PIPE_DEPTH < 3) begin : g_bad_pipe_depth
        $error("alu_threaded: PIPE_DEPTH must be >= 3");
    end

    localparam int SHAMT_W = $clog2(WORD_WIDTH);
    // Issue register + (DLY) delay registers + output register = PIPE_DEPTH.
    localparam int DLY     = PIPE_DEPTH - 2;

    typedef enum logic [3:0] {
        OP_ADD     = 4'd0,
        OP_ADC     = 4'd1,
        OP_SUB     = 4'd2,
        OP_SBB     = 4'd3,
        OP_AND     = 4'd4,
        OP_OR      = 4'd5,
        OP_XOR     = 4'd6,
        OP_PASS    = 4'd7,
        OP_SHL     = 4'd8,
        OP_SHR     = 4'd9,
        OP_SAR     = 4'd10,
        OP_ROL     = 4'd11,
        OP_MUL_LO  = 4'd12,
        OP_MUL_HI  = 4'd13,
        OP_MULS_HI = 4'd14,
        OP_PASS_B  = 4'd15
    } opcode_e;

    typedef struct packed {
        logic                       valid;
        logic [TID_WIDTH-1:0]       tid;
        logic [3:0]                 op;
        logic [D_OPERAND_WIDTH-1:0] d;
        logic [WORD_WIDTH-1:0]      a;
        logic [WORD_WIDTH-1:0]      b;
        logic                       cin;
    } issue_t;

    typedef struct packed {
        logic                       valid;
        logic [TID_WIDTH-1:0]       tid;
        logic [3:0]                 op;
        logic [D_OPERAND_WIDTH-1:0] d;
        logic [WORD_WIDTH-1:0]      r;
        logic                       c_new;
        logic                       c_wr;
    } stage_t;

    // ------------------------------------------------------------------
    // Per-thread carry file
    // ------------------------------------------------------------------
    logic [THREAD_COUNT-1:0] r_carry;

    // ------------------------------------------------------------------
    // Issue register. The carry is captured here, so an op issued in the
    // same cycle a same-thread producer becomes visible sees the new value
    // (the file was written on the edge that made the producer visible).
    // ------------------------------------------------------------------
    issue_t r_iss;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_iss <= '0;
        end else begin
            r_iss <= '{valid: in_valid,
                       tid:   thread_in,
                       op:    op_in,
                       d:     D_in,
                       a:     A,
                       b:     B,
                       cin:   r_carry[thread_in]};
        end
    end

    // ------------------------------------------------------------------
    // Adder: one W+1 bit adder shared by ADD/ADC/SUB/SBB.
    // For subtraction B is inverted; carry-out of 1 means "no borrow".
    // ------------------------------------------------------------------
    logic                  w_is_sub;
    logic [WORD_WIDTH-1:0] w_b_eff;
    logic                  w_cin_eff;
    logic [WORD_WIDTH:0]   w_sum;

    assign w_is_sub = (r_iss.op == OP_SUB) || (r_iss.op == OP_SBB);
    assign w_b_eff  = w_is_sub ? ~r_iss.b : r_iss.b;

    always_comb begin
        w_cin_eff = 1'b0;
        case (r_iss.op)
            OP_ADC, OP_SBB: w_cin_eff = r_iss.cin;
            OP_SUB:         w_cin_eff = 1'b1;
            default:        w_cin_eff = 1'b0;
        endcase
    end

    assign w_sum = {1'b0, r_iss.a} + {1'b0, w_b_eff}
                 + {{WORD_WIDTH{1'b0}}, w_cin_eff};

    // ------------------------------------------------------------------
    // Shifter. Amounts at or above WORD_WIDTH are only reachable when
    // WORD_WIDTH is not a power of two; they saturate for SHL/SHR/SAR and
    // wrap for ROL. The amount field is < 2*WORD_WIDTH, so one
    // subtraction is enough to reduce it modulo WORD_WIDTH.
    // ------------------------------------------------------------------
    logic [SHAMT_W-1:0]      w_amt;
    logic                    w_shift_big;
    logic [WORD_WIDTH-1:0]   w_shl;
    logic [WORD_WIDTH-1:0]   w_shr;
    logic [WORD_WIDTH-1:0]   w_sar_raw;
    logic [WORD_WIDTH-1:0]   w_sar;
    logic [SHAMT_W-1:0]      w_rol_k;
    logic [2*WORD_WIDTH-1:0] w_rol_dbl;
    logic [WORD_WIDTH-1:0]   w_rol;

    assign w_amt       = r_iss.b[SHAMT_W-1:0];
    assign w_shift_big = ({1'b0, w_amt} >= (SHAMT_W+1)'(WORD_WIDTH));
    assign w_shl       = w_shift_big ? '0 : (r_iss.a << w_amt);
    assign w_shr       = w_shift_big ? '0 : (r_iss.a >> w_amt);
    assign w_sar_raw   = $signed(r_iss.a) >>> w_amt;
    assign w_sar       = w_shift_big ? {WORD_WIDTH{r_iss.a[WORD_WIDTH-1]}} : w_sar_raw;
    assign w_rol_k     = w_shift_big ? (w_amt - SHAMT_W'(WORD_WIDTH)) : w_amt;
    // Rotating left = shifting a doubled word and keeping the upper half.
    assign w_rol_dbl   = {r_iss.a, r_iss.a} << w_rol_k;
    assign w_rol       = w_rol_dbl[2*WORD_WIDTH-1:WORD_WIDTH];

`ifdef ALU_MULT_EN
    // ------------------------------------------------------------------
    // Multiplier. A single unsigned product; the signed high word is
    // derived from it: hi_s = hi_u - (A<0 ? B : 0) - (B<0 ? A : 0).
    // The multiplier sits ahead of DLY plain registers that a retiming
    // synthesis flow can pull into the array.
    // ------------------------------------------------------------------
    logic [2*WORD_WIDTH-1:0] w_prod;
    logic [WORD_WIDTH-1:0]   w_muls_hi;

    assign w_prod    = {{WORD_WIDTH{1'b0}}, r_iss.a} * {{WORD_WIDTH{1'b0}}, r_iss.b};
    assign w_muls_hi = w_prod[2*WORD_WIDTH-1:WORD_WIDTH]
                     - (r_iss.a[WORD_WIDTH-1] ? r_iss.b : '0)
                     - (r_iss.b[WORD_WIDTH-1] ? r_iss.a : '0);
`endif

    // ------------------------------------------------------------------
    // Result select
    // ------------------------------------------------------------------
    logic [WORD_WIDTH-1:0] w_result;

    always_comb begin
        w_result = '0;
        case (r_iss.op)
            OP_ADD, OP_ADC,
            OP_SUB, OP_SBB: w_result = w_sum[WORD_WIDTH-1:0];
            OP_AND:         w_result = r_iss.a & r_iss.b;
            OP_OR:          w_result = r_iss.a | r_iss.b;
            OP_XOR:         w_result = r_iss.a ^ r_iss.b;
            OP_PASS:        w_result = r_iss.a;
            OP_SHL:         w_result = w_shl;
            OP_SHR:         w_result = w_shr;
            OP_SAR:         w_result = w_sar;
            OP_ROL:         w_result = w_rol;
`ifdef ALU_MULT_EN
            OP_MUL_LO:      w_result = w_prod[WORD_WIDTH-1:0];
            OP_MUL_HI:      w_result = w_prod[2*WORD_WIDTH-1:WORD_WIDTH];
            OP_MULS_HI:     w_result = w_muls_hi;
`endif
            OP_PASS_B:      w_result = r_iss.b;
            default:        w_result = '0;
        endcase
    end

    stage_t w_exe;

    assign w_exe = '{valid: r_iss.valid,
                     tid:   r_iss.tid,
                     op:    r_iss.op,
                     d:     r_iss.d,
                     r:     w_result,
                     c_new: w_sum[WORD_WIDTH],
                     c_wr:  (r_iss.op <= OP_SBB)};

    // ------------------------------------------------------------------
    // Delay line: result and bookkeeping travel together
    // ------------------------------------------------------------------
    stage_t r_dly [DLY];
    stage_t w_ret;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DLY; i++) begin
                r_dly[i] <= '0;
            end
        end else begin
            r_dly[0] <= w_exe;
            for (int i = 1; i < DLY; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    assign w_ret = r_dly[DLY-1];

    // ------------------------------------------------------------------
    // Output register and carry retirement (same edge)
    // ------------------------------------------------------------------
    logic                       r_out_valid;
    logic [TID_WIDTH-1:0]       r_thread_out;
    logic [3:0]                 r_op_out;
    logic [D_OPERAND_WIDTH-1:0] r_d_out;
    logic [WORD_WIDTH-1:0]      r_r;
    logic                       r_carry_out;
    logic                       r_zero_out;
    logic                       r_negative_out;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_carry        <= '0;
            r_out_valid    <= 1'b0;
            r_thread_out   <= '0;
            r_op_out       <= '0;
            r_d_out        <= '0;
            r_r            <= '0;
            r_carry_out    <= 1'b0;
            r_zero_out     <= 1'b0;
            r_negative_out <= 1'b0;
        end else begin
            r_out_valid    <= w_ret.valid;
            r_thread_out   <= w_ret.tid;
            r_op_out       <= w_ret.op;
            r_d_out        <= w_ret.d;
            r_r            <= w_ret.r;
            r_zero_out     <= (w_ret.r == '0);
            r_negative_out <= w_ret.r[WORD_WIDTH-1];
            if (w_ret.valid && w_ret.c_wr) begin
                r_carry[w_ret.tid] <= w_ret.c_new;
                r_carry_out        <= w_ret.c_new;
            end else begin
                // Non-carry ops report the thread's carry as it stands now.
                r_carry_out <= r_carry[w_ret.tid];
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign thread_out   = r_thread_out;
    assign op_out       = r_op_out;
    assign D_out        = r_d_out;
    assign R            = r_r;
    assign carry_out    = r_carry_out;
    assign zero_out     = r_zero_out;
    assign negative_out = r_negative_out;

endmodule

// File: doc/alu_threaded.md
# alu_threaded

Fully pipelined, fixed-latency integer ALU for the barrel-threaded datapath. It replaces the externally supplied carry with per-thread carry state and adds shifts, rotates and result flags. Latency, word width and thread count are parameters. It sits between operand fetch (A/B memories) and write-back, and carries the destination operand D and the thread ID alongside each result.

## Interface
- WORD_WIDTH, 36, data width; must be ≥ 8.
- OPCODE_WIDTH, 4, opcode width; fixed at 4 and checked at elaboration.
- D_OPERAND_WIDTH, 10, destination address carried through.
- THREAD_COUNT, 8, number of hardware threads; must be ≥ 2.
- PIPE_DEPTH, 8, total input-to-output latency in cycles; must be ≥ 3. Elaboration error otherwise.
- TID_WIDTH, clog2(THREAD_COUNT), thread ID width.
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation present this cycle.
- thread_in  in  TID_WIDTH  issuing thread.
- op_in  in  4  opcode.
- D_in  in  D_OPERAND_WIDTH  destination operand.
- A, B  in  WORD_WIDTH each  operands.
- out_valid  out  1  result valid.
- thread_out  out  TID_WIDTH  thread of result.
- op_out  out  4  opcode of result.
- D_out  out  D_OPERAND_WIDTH  delayed D.
- R  out  WORD_WIDTH  result.
- carry_out  out  1  the thread's carry after this op.
- zero_out  out  1  R == 0.
- negative_out  out  1  R[WORD_WIDTH-1].

## Operation
Opcodes:
- 0 ADD: A+B.
- 1 ADC: A+B+C.
- 2 SUB: A+~B+1.
- 3 SBB: A+~B+C.
- 4 AND. 5 OR. 6 XOR.
- 7 PASS: R=A.
- 8 SHL. 9 SHR logical. 10 SAR. 11 ROL.
- 12 MUL_LO: unsigned, low word.
- 13 MUL_HI: unsigned, high word.
- 14 MULS_HI: signed, high word.
- 15 PASS_B: R=B.

Arithmetic and carry rules:
- C is the issuing thread's carry register.
- Adder carry is the carry out of bit WORD_WIDTH-1. For SUB/SBB, carry=1 means no borrow.
- Only opcodes 0–3 write the per-thread carry. All other opcodes leave it unchanged, and carry_out reports the unchanged value.
- The MUL_LO result is identical for signed and unsigned operands.

Shift rules:
- Amount is B[clog2(WORD_WIDTH)-1:0], treated as unsigned.
- If amount ≥ WORD_WIDTH: SHL/SHR give 0, SAR gives a full sign fill, and ROL uses amount mod WORD_WIDTH.

Pipeline bookkeeping:
- Every functional unit's result is delay-matched to exactly PIPE_DEPTH. The multiplier may be internally pipelined up to PIPE_DEPTH-1 stages.
- op, D, thread and valid travel in a delay line of the same depth.
- Invalid slots flow through with out_valid=0. They never write carry. R/flags in those slots are don't-care but deterministic.
- Per-thread carry file: THREAD_COUNT flops, read combinationally at issue, written at retirement.

## Timing
- Throughput: one op per cycle, no stalls, no backpressure.
- Latency: op sampled at the end of cycle n appears on all outputs in cycle n+PIPE_DEPTH.
- Carry write occurs on the same edge that registers R. A same-thread ADC/SBB issued in the cycle its producer's result is visible reads the new carry.
- Issue spacing < PIPE_DEPTH reads the stale carry. This is the defined behaviour; round-robin with THREAD_COUNT ≥ PIPE_DEPTH avoids it.
- Two threads retiring and issuing in the same cycle are independent. A same-thread read and write in the same cycle follows the rule above.
- Reset (asynchronous, any cycle including mid-stream):
  - All pipeline valid bits cleared, all carry flops = 0.
  - R=0, op_out=0, D_out=0, thread_out=0, out_valid=0, all flags=0.
  - In-flight ops are discarded.
  - First op after release retires PIPE_DEPTH cycles later.

## Configuration
- ALU_MULT_EN defined: multiplier instantiated; opcodes 12–14 as above.
- ALU_MULT_EN undefined: no multiplier hardware. Opcodes 12–14 give R=0, zero_out=1, carry unchanged. Latency is unchanged.

## Test plan
Parameters for all tests: WORD_WIDTH=36, PIPE_DEPTH=8, THREAD_COUNT=8.
- ADD with thread 3, A=0xFFFFFFFFF, B=1, issued cycle 0 -> cycle 8: R=0, carry_out=1, zero_out=1. Then ADC with thread 3, A=0, B=0, issued cycle 8 -> cycle 16: R=1, carry_out=0.
- Thread isolation: carry of thread 1 set as above. ADC with thread 4, A=0, B=0 -> R=0. Thread 1 ADC issued 3 cycles after its ADD (stale) -> R=0.
- SUB A=5, B=7 -> R=0xFFFFFFFFE, carry_out=0, negative_out=1. Next SBB for that thread, A=10, B=2 -> R=7.
- Shifts:
  - SAR A=0x800000000, B=40 -> 0xFFFFFFFFF.
  - SHL A=1, B=36 -> 0.
  - ROL A=1, B=37 -> 2.
  - SHR A=0x800000000, B=35 -> 1.
- Multiplies:
  - MULS_HI A=B=0xFFFFFFFFF -> 0. MUL_LO same operands -> 1. MUL_HI same operands -> 0xFFFFFFFFE.
  - With ALU_MULT_EN undefined -> R=0, carry unchanged.
- Stream 16 opcodes back-to-back across rotating threads, then pull reset_n low at cycle 5 -> out_valid stays 0 through cycle 13 and all carries read 0. Without reset, results appear in order, one per cycle, from cycle 8.
